// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit sitting directly after instruction decode.
// Takes one memory micro-op at a time and runs it on a req/gnt/rvalid
// data bus. It returns the extended load data, or a completion for
// stores, no-ops and faulting ops, over a valid/ready handshake.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   in_*              decoded micro-op handshake and fields (addr, wdata,
//                     mwen, mren, unsign). Sizes: 00 none, 01 byte,
//                     10 half, 11 word.
//   mem_*             data-memory bus: word-aligned address, replicated
//                     store data, byte strobes, read data return
//   out_*             result to write-back: rdata, err, valid/ready
module lsu_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [1:0]        in_mwen,
  input  logic [1:0]        in_mren,
  input  logic              in_unsign,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e            state_q;
  logic              in_ready_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              unsign_q;
  logic              mem_req_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_rdata_q;
  logic              out_err_q;

  // Classification and lane steering of the op presented at the input.
  logic [1:0]        size_d;
  logic              illegal_d;
  logic              misalign_d;
  logic [DATA_W-1:0] wdata_d;
  logic [3:0]        wstrb_d;

  always_comb begin
    size_d     = in_mwen | in_mren;
    illegal_d  = (|in_mwen) && (|in_mren);
    misalign_d = ((size_d == 2'b10) && in_addr[0]) ||
                 ((size_d == 2'b11) && (|in_addr[1:0]));
    wdata_d    = in_wdata;
    wstrb_d    = 4'b0000;
    // Faulting ops never strobe any byte lane.
    if (!illegal_d && !misalign_d) begin
      case (in_mwen)
        2'b01: begin
          wdata_d = {4{in_wdata[7:0]}};
          wstrb_d = 4'b0001 << in_addr[1:0];
        end
        2'b10: begin
          wdata_d = {2{in_wdata[15:0]}};
          wstrb_d = 4'b0011 << in_addr[1:0];
        end
        2'b11: begin
          wdata_d = in_wdata;
          wstrb_d = 4'b1111;
        end
        default: ;
      endcase
    end
  end

  // Load extraction: shift the addressed lane down, then extend.
  logic [DATA_W-1:0] shifted_d;
  logic [DATA_W-1:0] load_d;

  always_comb begin
    shifted_d = mem_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b01:   load_d = {{(DATA_W-8){~unsign_q & shifted_d[7]}}, shifted_d[7:0]};
      2'b10:   load_d = {{(DATA_W-16){~unsign_q & shifted_d[15]}}, shifted_d[15:0]};
      default: load_d = shifted_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= 4'b0000;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      unsign_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_rdata_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // in_ready comes up on the first clock after reset.
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            in_ready_q  <= 1'b0;
            addr_q      <= in_addr;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            we_q        <= |in_mwen;
            size_q      <= size_d;
            unsign_q    <= in_unsign;
            out_rdata_q <= '0;
            out_err_q   <= 1'b0;
            if (illegal_d || misalign_d) begin
              out_err_q   <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= RESP;
            end else if (size_d == 2'b00) begin
              out_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              mem_req_q <= 1'b1;
              state_q   <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            if (we_q) begin
              out_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            out_rdata_q <= load_d;
            out_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign out_valid = out_valid_q;
  assign out_rdata = out_rdata_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit: loads/stores of each size, faults,
// backpressure and reset in the middle of a read.
module tb_lsu_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [1:0]  in_mwen;
  logic [1:0]  in_mren;
  logic        in_unsign;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;

  int errors = 0;
  int checks = 0;

  lsu_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_wdata   (in_wdata),
    .in_mwen    (in_mwen),
    .in_mren    (in_mren),
    .in_unsign  (in_unsign),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rdata  (out_rdata),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single accepting cycle.
  task automatic issue(input logic [1:0] mwen, input logic [1:0] mren,
                       input logic unsign, input logic [31:0] addr,
                       input logic [31:0] wdata);
    in_valid  = 1'b1;
    in_mwen   = mwen;
    in_mren   = mren;
    in_unsign = unsign;
    in_addr   = addr;
    in_wdata  = wdata;
    step();
    in_valid  = 1'b0;
  endtask

  // Load with gnt in the first REQ cycle and rvalid the cycle after.
  task automatic do_load(input string tag, input logic [1:0] mren, input logic unsign,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [31:0] exp);
    issue(2'b00, mren, unsign, addr, 32'h0);
    chk({tag, ".req"}, 32'(mem_req), 32'd1);
    chk({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
    chk({tag, ".we"}, 32'(mem_we), 32'd0);
    chk({tag, ".strb"}, 32'(mem_wstrb), 32'd0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk({tag, ".wait_req"}, 32'(mem_req), 32'd0);
    chk({tag, ".wait_valid"}, 32'(out_valid), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".rdata"}, out_rdata, exp);
    chk({tag, ".err"}, 32'(out_err), 32'd0);
    step();
    chk({tag, ".done"}, 32'(out_valid), 32'd0);
    chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    $display("load  %s addr=%h rdata=%h -> out=%h", tag, addr, rdata, exp);
  endtask

  // Store with gnt after 'delay' un-granted REQ cycles.
  task automatic do_store(input string tag, input logic [1:0] mwen, input logic [31:0] addr,
                          input logic [31:0] wdata, input int delay,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_strb);
    issue(mwen, 2'b00, 1'b0, addr, wdata);
    for (int i = 0; i <= delay; i++) begin
      chk({tag, ".req"}, 32'(mem_req), 32'd1);
      chk({tag, ".we"}, 32'(mem_we), 32'd1);
      chk({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
      chk({tag, ".wdata"}, mem_wdata, exp_wdata);
      chk({tag, ".strb"}, 32'(mem_wstrb), 32'(exp_strb));
      chk({tag, ".nvalid"}, 32'(out_valid), 32'd0);
      mem_gnt = (i == delay);
      step();
    end
    mem_gnt = 1'b0;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".rdata"}, out_rdata, 32'h0);
    chk({tag, ".err"}, 32'(out_err), 32'd0);
    chk({tag, ".req_off"}, 32'(mem_req), 32'd0);
    step();
    chk({tag, ".done"}, 32'(out_valid), 32'd0);
    $display("store %s addr=%h wdata=%h strb=%b", tag, addr, exp_wdata, exp_strb);
  endtask

  // Op resolved at acceptance: no bus activity, result next cycle.
  task automatic do_quick(input string tag, input logic [1:0] mwen, input logic [1:0] mren,
                          input logic [31:0] addr, input logic exp_err);
    issue(mwen, mren, 1'b0, addr, 32'hDEAD_BEEF);
    chk({tag, ".req"}, 32'(mem_req), 32'd0);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".err"}, 32'(out_err), 32'(exp_err));
    chk({tag, ".rdata"}, out_rdata, 32'h0);
    step();
    chk({tag, ".done"}, 32'(out_valid), 32'd0);
    chk({tag, ".idle_req"}, 32'(mem_req), 32'd0);
    $display("quick %s mwen=%b mren=%b addr=%h err=%b", tag, mwen, mren, addr, exp_err);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_addr    = 32'h0;
    in_wdata   = 32'h0;
    in_mwen    = 2'b00;
    in_mren    = 2'b00;
    in_unsign  = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    out_ready  = 1'b1;

    // Reset state
    #7;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_rdata", out_rdata, 32'h0);
    chk("rst.out_err", 32'(out_err), 32'd0);
    chk("rst.mem_wstrb", 32'(mem_wstrb), 32'd0);
    #5 rst_n = 1'b1;
    step();
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);
    $display("reset released, in_ready=%b", in_ready);

    // Loads
    do_load("LB",   2'b01, 1'b0, 32'h8000_0003, 32'h80FF_1234, 32'hFFFF_FF80);
    do_load("LHU",  2'b10, 1'b1, 32'h8000_0002, 32'hBEEF_0000, 32'h0000_BEEF);
    do_load("LH",   2'b10, 1'b0, 32'h8000_0002, 32'hBEEF_0000, 32'hFFFF_BEEF);
    do_load("LBU1", 2'b01, 1'b1, 32'h8000_0001, 32'h0000_A500, 32'h0000_00A5);
    do_load("LB0",  2'b01, 1'b0, 32'h8000_0000, 32'h1234_567F, 32'h0000_007F);
    do_load("LW",   2'b11, 1'b0, 32'h8000_0004, 32'h1234_5678, 32'h1234_5678);

    // Stores
    do_store("SB", 2'b01, 32'h1000_0001, 32'h1234_56AB, 3, 32'hABAB_ABAB, 4'b0010);
    do_store("SH", 2'b10, 32'h1000_0002, 32'hCAFE_1234, 0, 32'h1234_1234, 4'b1100);
    do_store("SW", 2'b11, 32'h1000_000C, 32'hCAFE_1234, 1, 32'hCAFE_1234, 4'b1111);

    // Faults and no-op
    do_quick("LW_mis",  2'b00, 2'b11, 32'h8000_0002, 1'b1);
    do_quick("illegal", 2'b01, 2'b01, 32'h8000_0000, 1'b1);
    do_quick("LH_mis",  2'b00, 2'b10, 32'h8000_0003, 1'b1);
    do_quick("SW_mis",  2'b11, 2'b00, 32'h8000_0001, 1'b1);
    do_quick("noop",    2'b00, 2'b00, 32'h8000_0003, 1'b0);

    // Backpressure on a completed load; a pending op must not be taken.
    out_ready = 1'b0;
    issue(2'b00, 2'b10, 1'b0, 32'h2000_0000, 32'h0);
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_8001;
    step();
    mem_rvalid = 1'b0;
    in_valid   = 1'b1;
    in_mwen    = 2'b00;
    in_mren    = 2'b00;
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", 32'(out_valid), 32'd1);
      chk("bp.rdata", out_rdata, 32'hFFFF_8001);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk("bp.mem_req", 32'(mem_req), 32'd0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp.still_valid", 32'(out_valid), 32'd1);
    step();
    chk("bp.released", 32'(out_valid), 32'd0);
    chk("bp.in_ready", 32'(in_ready), 32'd1);
    $display("backpressure 5 cycles, rdata=%h", 32'hFFFF_8001);

    // Reset while waiting for read data; a late rvalid is ignored.
    issue(2'b00, 2'b11, 1'b0, 32'h3000_0000, 32'h0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("mid.wait_req", 32'(mem_req), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.rst_valid", 32'(out_valid), 32'd0);
    chk("mid.rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid.rst_addr", mem_addr, 32'h0);
    #1 rst_n = 1'b1;
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    step();
    mem_rvalid = 1'b0;
    chk("mid.no_valid", 32'(out_valid), 32'd0);
    chk("mid.in_ready", 32'(in_ready), 32'd1);
    chk("mid.rdata", out_rdata, 32'h0);
    step();
    chk("mid.no_valid2", 32'(out_valid), 32'd0);
    chk("mid.no_req", 32'(mem_req), 32'd0);
    $display("reset during WAIT, stale rvalid ignored");

    // Unit still works after the abandoned access.
    do_load("LW2", 2'b11, 1'b0, 32'h8000_0008, 32'hA5A5_0F0F, 32'hA5A5_0F0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
